axi_mem_responder: RTL and testbench

AXI4 slave memory model that answers the GPGPU's 64-bit AXI master port on the FPGA test platform. It is the responder end of the m_axi interface. It accepts INCR bursts (GPGPU issues len=3, size=3), stores data in an on-chip array, and returns B and R responses with the matching IDs. Write and read channels run as independent engines over a one-write/one-read-port array.

---
 rtl/axi_mem_pkg.sv | 27 ++
 rtl/axi_mem_responder_if.sv | 73 +++++++
 rtl/axi_mem_array.sv | 46 ++++
 rtl/axi_mem_responder.sv | 237 +++++++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 376 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_mem_pkg.sv
// ---------------------------------------------------------------------------
// axi_mem_pkg
// Shared constants and FSM state types for the AXI4 memory responder.
//   RESP_OKAY / RESP_SLVERR : B/R response encodings
//   BURST_INCR, SIZE_8B     : the only burst type and beat size honoured
//   wr_state_t / rd_state_t : write and read engine states
// ---------------------------------------------------------------------------
package axi_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_8B     = 3'd3;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_DATA  = 2'd2
    } rd_state_t;

endpackage

// File: rtl/axi_mem_responder_if.sv
// ---------------------------------------------------------------------------
// axi_mem_responder_if
// AXI4 bus bundle between the GPGPU master port and the memory responder.
//   Modport slave  : the responder (drives ready on AW/W/AR, valid on B/R)
//   Modport master : the requester (bench or GPGPU side)
// Channels: AW, W, B, AR, R with the usual valid/ready handshakes.
// ---------------------------------------------------------------------------
interface axi_mem_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
);
    logic                  awvalid;
    logic                  awready;
    logic [ID_W-1:0]       awid;
    logic [ADDR_W-1:0]     awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;

    logic                  wvalid;
    logic                  wready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  wlast;

    logic                  bvalid;
    logic                  bready;
    logic [ID_W-1:0]       bid;
    logic [1:0]            bresp;

    logic                  arvalid;
    logic                  arready;
    logic [ID_W-1:0]       arid;
    logic [ADDR_W-1:0]     araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;

    logic                  rvalid;
    logic                  rready;
    logic [ID_W-1:0]       rid;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;
    logic                  rlast;

    modport slave (
        input  awvalid, awid, awaddr, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bid, bresp,
        input  bready,
        input  arvalid, arid, araddr, arlen, arsize, arburst,
        output arready,
        output rvalid, rid, rdata, rresp, rlast,
        input  rready
    );

    modport master (
        output awvalid, awid, awaddr, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bid, bresp,
        output bready,
        output arvalid, arid, araddr, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rid, rdata, rresp, rlast,
        output rready
    );

endinterface

// File: rtl/axi_mem_array.sv
// ---------------------------------------------------------------------------
// axi_mem_array
// MEM_WORDS x DATA_W storage, one write port with byte enables and one read
// port with a registered, read-first output. Contents are never reset.
//   clock   : sole clock
//   we_i    : write enable; waddr_i/wdata_i/wbe_i give word, data, byte lanes
//   re_i    : read enable; raddr_i selects the word, rdata_o updates next cycle
//   rdata_o : holds its value while re_i is low
// ---------------------------------------------------------------------------
module axi_mem_array #(
    parameter int DATA_W    = 64,
    parameter int MEM_WORDS = 4096,
    localparam int IDX_W    = $clog2(MEM_WORDS),
    localparam int BE_W     = DATA_W / 8
) (
    input  logic              clock,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [BE_W-1:0]   wbe_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [MEM_WORDS];
    logic [DATA_W-1:0] rdata_q;

    // Both ports are non-blocking in one process, so a same-word read and
    // write in one cycle returns the pre-write contents.
    always_ff @(posedge clock) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
        if (we_i) begin
            for (int b = 0; b < BE_W; b++) begin
                if (wbe_i[b]) begin
                    mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_mem_responder.sv
// ---------------------------------------------------------------------------
// axi_mem_responder
// AXI4 slave memory model answering the GPGPU m_axi port. Independent write
// and read engines share a 1W/1R array; one outstanding burst per direction.
//   clock : sole clock
//   reset : synchronous, active-high; all responder outputs forced to 0
//   s_axi : AXI4 slave modport (AW/W/B/AR/R)
//
// state   | meaning
// W_IDLE  | awready high, waiting for a write address
// W_DATA  | wready high, accepting len+1 write beats
// W_RESP  | bvalid high until bready
// R_IDLE  | arready high, waiting for a read address
// R_FETCH | array read of beat 0 in flight
// R_DATA  | rvalid high; next beat fetched on each non-last R fire
// ---------------------------------------------------------------------------
module axi_mem_responder
    import axi_mem_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 64,
    parameter int                ID_W      = 4,
    parameter int                MEM_WORDS = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                 clock,
    input  logic                 reset,
    axi_mem_responder_if.slave   s_axi
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int SHIFT = $clog2(DATA_W / 8);
    localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(MEM_WORDS);

    // ---------------- write engine ----------------
    wr_state_t         wr_state_q, wr_state_d;
    logic [ID_W-1:0]   wid_q, wid_d;
    logic [7:0]        wlen_q, wlen_d;
    logic [ADDR_W-1:0] widx_q, widx_d;
    logic [7:0]        wbeat_q, wbeat_d;
    logic              werr_q, werr_d;

    logic              awready_w, wready_w, bvalid_w;
    logic              aw_fire, w_fire, b_fire;
    logic [ADDR_W-1:0] w_word;
    logic              w_inr, w_is_last, mem_we;

    assign awready_w = (wr_state_q == W_IDLE) && !reset;
    assign wready_w  = (wr_state_q == W_DATA) && !reset;
    assign bvalid_w  = (wr_state_q == W_RESP) && !reset;
    assign aw_fire   = s_axi.awvalid && awready_w;
    assign w_fire    = s_axi.wvalid  && wready_w;
    assign b_fire    = bvalid_w && s_axi.bready;

    assign w_word    = widx_q + ADDR_W'(wbeat_q);
    assign w_inr     = w_word < DEPTH;
    assign w_is_last = (wbeat_q == wlen_q);
    // A beat is only committed when the burst is still clean and in range.
    assign mem_we    = w_fire && w_inr && !werr_q;

    always_comb begin
        wr_state_d = wr_state_q;
        wid_d      = wid_q;
        wlen_d     = wlen_q;
        widx_d     = widx_q;
        wbeat_d    = wbeat_q;
        werr_d     = werr_q;
        case (wr_state_q)
            W_IDLE: begin
                if (aw_fire) begin
                    wid_d      = s_axi.awid;
                    wlen_d     = s_axi.awlen;
                    widx_d     = (s_axi.awaddr - BASE_ADDR) >> SHIFT;
                    wbeat_d    = '0;
                    werr_d     = (s_axi.awsize != SIZE_8B) || (s_axi.awburst != BURST_INCR);
                    wr_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (w_fire) begin
                    if (!w_inr) begin
                        werr_d = 1'b1;
                    end
                    // The beat count decides completion; wlast is only audited.
                    if (s_axi.wlast != w_is_last) begin
                        werr_d = 1'b1;
                    end
                    wbeat_d = wbeat_q + 8'd1;
                    if (w_is_last) begin
                        wr_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (b_fire) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_state_q <= W_IDLE;
            wid_q      <= '0;
            wlen_q     <= '0;
            widx_q     <= '0;
            wbeat_q    <= '0;
            werr_q     <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            wid_q      <= wid_d;
            wlen_q     <= wlen_d;
            widx_q     <= widx_d;
            wbeat_q    <= wbeat_d;
            werr_q     <= werr_d;
        end
    end

    assign s_axi.awready = awready_w;
    assign s_axi.wready  = wready_w;
    assign s_axi.bvalid  = bvalid_w;
    assign s_axi.bid     = reset ? '0 : wid_q;
    assign s_axi.bresp   = (reset || !werr_q) ? RESP_OKAY : RESP_SLVERR;

    // ---------------- read engine ----------------
    rd_state_t         rd_state_q, rd_state_d;
    logic [ID_W-1:0]   rid_q, rid_d;
    logic [7:0]        rlen_q, rlen_d;
    logic [ADDR_W-1:0] ridx_q, ridx_d;
    logic [7:0]        rbeat_q, rbeat_d;
    logic              rerr_q, rerr_d;
    logic              rberr_q, rberr_d;   // error flag of the beat on the bus

    logic              arready_w, rvalid_w;
    logic              ar_fire, r_fire, r_is_last;
    logic [7:0]        fetch_beat;
    logic [ADDR_W-1:0] r_word;
    logic              r_inr, fetch_now, mem_re;
    logic [DATA_W-1:0] mem_rdata;

    assign arready_w  = (rd_state_q == R_IDLE) && !reset;
    assign rvalid_w   = (rd_state_q == R_DATA) && !reset;
    assign ar_fire    = s_axi.arvalid && arready_w;
    assign r_fire     = rvalid_w && s_axi.rready;
    assign r_is_last  = (rbeat_q == rlen_q);

    // In R_FETCH the beat counter still points at beat 0; in R_DATA the
    // fetch targets the beat after the one being handed over.
    assign fetch_beat = (rd_state_q == R_DATA) ? (rbeat_q + 8'd1) : rbeat_q;
    assign r_word     = ridx_q + ADDR_W'(fetch_beat);
    assign r_inr      = r_word < DEPTH;
    assign fetch_now  = (rd_state_q == R_FETCH) ||
                        ((rd_state_q == R_DATA) && r_fire && !r_is_last);
    assign mem_re     = fetch_now && r_inr && !rerr_q;

    always_comb begin
        rd_state_d = rd_state_q;
        rid_d      = rid_q;
        rlen_d     = rlen_q;
        ridx_d     = ridx_q;
        rbeat_d    = rbeat_q;
        rerr_d     = rerr_q;
        rberr_d    = rberr_q;
        case (rd_state_q)
            R_IDLE: begin
                if (ar_fire) begin
                    rid_d      = s_axi.arid;
                    rlen_d     = s_axi.arlen;
                    ridx_d     = (s_axi.araddr - BASE_ADDR) >> SHIFT;
                    rbeat_d    = '0;
                    rerr_d     = (s_axi.arsize != SIZE_8B) || (s_axi.arburst != BURST_INCR);
                    rd_state_d = R_FETCH;
                end
            end
            R_FETCH: begin
                rberr_d    = rerr_q || !r_inr;
                rd_state_d = R_DATA;
            end
            R_DATA: begin
                if (r_fire) begin
                    if (r_is_last) begin
                        rd_state_d = R_IDLE;
                    end else begin
                        rbeat_d = rbeat_q + 8'd1;
                        rberr_d = rerr_q || !r_inr;
                    end
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_state_q <= R_IDLE;
            rid_q      <= '0;
            rlen_q     <= '0;
            ridx_q     <= '0;
            rbeat_q    <= '0;
            rerr_q     <= 1'b0;
            rberr_q    <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            rid_q      <= rid_d;
            rlen_q     <= rlen_d;
            ridx_q     <= ridx_d;
            rbeat_q    <= rbeat_d;
            rerr_q     <= rerr_d;
            rberr_q    <= rberr_d;
        end
    end

    assign s_axi.arready = arready_w;
    assign s_axi.rvalid  = rvalid_w;
    assign s_axi.rid     = reset ? '0 : rid_q;
    assign s_axi.rdata   = (rvalid_w && !rberr_q) ? mem_rdata : '0;
    assign s_axi.rresp   = (reset || !rberr_q) ? RESP_OKAY : RESP_SLVERR;
    assign s_axi.rlast   = rvalid_w && r_is_last;

    // ---------------- storage ----------------
    axi_mem_array #(
        .DATA_W    (DATA_W),
        .MEM_WORDS (MEM_WORDS)
    ) u_array (
        .clock   (clock),
        .we_i    (mem_we),
        .waddr_i (w_word[IDX_W-1:0]),
        .wdata_i (s_axi.wdata),
        .wbe_i   (s_axi.wstrb),
        .re_i    (mem_re),
        .raddr_i (r_word[IDX_W-1:0]),
        .rdata_o (mem_rdata)
    );

endmodule

// File: tb/tb_axi_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_axi_mem_responder
// Self-checking bench for axi_mem_responder: a table of write/read bursts
// checked against a word-level memory model, an R-channel scoreboard, and
// hand-written sequences for stalls, held B responses and mid-burst reset.
// ---------------------------------------------------------------------------
module tb_axi_mem_responder;
    import axi_mem_pkg::*;

    localparam int          ADDR_W    = 32;
    localparam int          DATA_W    = 64;
    localparam int          ID_W      = 4;
    localparam int          MEM_WORDS = 4096;
    localparam logic [31:0] BASE      = 32'h0000_0000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    axi_mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

    axi_mem_responder #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .ID_W      (ID_W),
        .MEM_WORDS (MEM_WORDS),
        .BASE_ADDR (BASE)
    ) dut (
        .clock (clock),
        .reset (reset),
        .s_axi (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s: timed out waiting for handshake", name);
    endtask

    // word-level memory model (absent entry = contents unknown)
    logic [63:0] mem_m [int unsigned];

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
        bit          chk_data;
    } rexp_t;
    rexp_t sb[$];
    int beats_seen = 0;

    // R monitor: sampled on the falling edge, a fire happens at the next rise
    initial begin
        rexp_t e;
        forever begin
            @(negedge clock);
            if (!reset && bus.rvalid) begin
                if (sb.size() == 0) begin
                    if (bus.rready) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL r_extra: unexpected beat rdata=0x%0h", bus.rdata);
                    end
                end else begin
                    e = sb[0];
                    if (e.chk_data) chk("rdata", bus.rdata, e.data);
                    chk("rresp", 64'(bus.rresp), 64'(e.resp));
                    chk("rlast", 64'(bus.rlast), 64'(e.last));
                    chk("rid", 64'(bus.rid), 64'(e.id));
                    if (bus.rready) begin
                        void'(sb.pop_front());
                        beats_seen++;
                    end
                end
            end
        end
    end

    task automatic push_read(input logic [31:0] addr, input logic [7:0] len,
                             input logic [3:0] id, input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] idx;
        bit          err;
        rexp_t       e;
        idx = (addr - BASE) >> 3;
        err = (size != 3'd3) || (burst != 2'b01);
        for (int k = 0; k <= int'(len); k++) begin
            int unsigned w;
            w = idx + k;
            e.id = id;
            e.last = (k == int'(len));
            e.chk_data = 1'b1;
            e.data = '0;
            e.resp = 2'b00;
            if (err || w >= MEM_WORDS) begin
                e.resp = 2'b10;
            end else if (mem_m.exists(w)) begin
                e.data = mem_m[w];
            end else begin
                e.chk_data = 1'b0;
            end
            sb.push_back(e);
        end
    endtask

    task automatic write_burst(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                               input logic [2:0] size, input logic [1:0] burst, input logic [7:0] strb,
                               input logic [63:0] seed, input int wl_beat, input logic [1:0] exp_resp,
                               input int bhold);
        bit          err;
        logic [31:0] idx;
        int          t;
        bus.awvalid = 1'b1;
        bus.awid    = id;
        bus.awaddr  = addr;
        bus.awlen   = len;
        bus.awsize  = size;
        bus.awburst = burst;
        t = 0;
        while (!bus.awready && t < 50) begin @(posedge clock); #1; t++; end
        if (!bus.awready) timeout_fail("aw_wait");
        @(posedge clock); #1;
        bus.awvalid = 1'b0;
        err = (size != 3'd3) || (burst != 2'b01);
        idx = (addr - BASE) >> 3;
        for (int k = 0; k <= int'(len); k++) begin
            int unsigned w;
            logic [63:0] d;
            d = seed * 64'(k + 1);
            bus.wvalid = 1'b1;
            bus.wdata  = d;
            bus.wstrb  = strb;
            bus.wlast  = (k == wl_beat);
            t = 0;
            while (!bus.wready && t < 50) begin @(posedge clock); #1; t++; end
            if (!bus.wready) timeout_fail("w_wait");
            @(posedge clock); #1;
            w = idx + k;
            if (!err && w < MEM_WORDS) begin
                if (mem_m.exists(w)) begin
                    for (int b = 0; b < 8; b++) if (strb[b]) mem_m[w][b*8 +: 8] = d[b*8 +: 8];
                end else if (strb == 8'hFF) begin
                    mem_m[w] = d;
                end
            end
            if (w >= MEM_WORDS) err = 1'b1;
            if ((k == wl_beat) != (k == int'(len))) err = 1'b1;
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        chk("bvalid_after_last_w", 64'(bus.bvalid), 64'd1);
        for (int h = 0; h < bhold; h++) begin
            chk("bvalid_hold", 64'(bus.bvalid), 64'd1);
            chk("bid_hold", 64'(bus.bid), 64'(id));
            chk("awready_in_resp", 64'(bus.awready), 64'd0);
            @(posedge clock); #1;
        end
        bus.bready = 1'b1;
        chk("bid", 64'(bus.bid), 64'(id));
        chk("bresp", 64'(bus.bresp), 64'(exp_resp));
        @(posedge clock); #1;
        bus.bready = 1'b0;
        chk("bvalid_after_b", 64'(bus.bvalid), 64'd0);
        chk("awready_after_b", 64'(bus.awready), 64'd1);
    endtask

    task automatic read_burst(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                              input logic [2:0] size, input logic [1:0] burst,
                              input logic [15:0] pat, input int plen);
        int t;
        int i;
        push_read(addr, len, id, size, burst);
        beats_seen = 0;
        bus.arvalid = 1'b1;
        bus.arid    = id;
        bus.araddr  = addr;
        bus.arlen   = len;
        bus.arsize  = size;
        bus.arburst = burst;
        t = 0;
        while (!bus.arready && t < 50) begin @(posedge clock); #1; t++; end
        if (!bus.arready) timeout_fail("ar_wait");
        @(posedge clock); #1;
        bus.arvalid = 1'b0;
        chk("rvalid_T1", 64'(bus.rvalid), 64'd0);
        @(posedge clock); #1;
        chk("rvalid_T2", 64'(bus.rvalid), 64'd1);
        i = 0;
        t = 0;
        while (sb.size() > 0 && t < 300) begin
            bus.rready = (i < plen) ? pat[i] : 1'b1;
            @(posedge clock); #1;
            i++;
            t++;
        end
        if (sb.size() > 0) begin
            timeout_fail("r_burst");
            sb.delete();
        end
        bus.rready = 1'b0;
        chk("rvalid_after_last", 64'(bus.rvalid), 64'd0);
        chk("arready_after_last", 64'(bus.arready), 64'd1);
        chk("beat_count", 64'(beats_seen), 64'(len) + 64'd1);
    endtask

    typedef struct {
        bit          rd;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [3:0]  id;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [7:0]  strb;
        logic [63:0] seed;
        int          wl;
        logic [1:0]  exp_resp;
    } vec_t;

    function automatic vec_t mk(input bit rd, input logic [31:0] addr, input logic [7:0] len,
                                input logic [3:0] id, input logic [2:0] size, input logic [1:0] burst,
                                input logic [7:0] strb, input logic [63:0] seed, input int wl,
                                input logic [1:0] exp_resp);
        vec_t v;
        v.rd = rd; v.addr = addr; v.len = len; v.id = id; v.size = size; v.burst = burst;
        v.strb = strb; v.seed = seed; v.wl = wl; v.exp_resp = exp_resp;
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        bus.awvalid = 0; bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
        bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.bready = 0;
        bus.arvalid = 0; bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
        bus.rready = 0;

        // reset state
        reset = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("rst_awready", 64'(bus.awready), 64'd0);
        chk("rst_arready", 64'(bus.arready), 64'd0);
        chk("rst_wready", 64'(bus.wready), 64'd0);
        chk("rst_bvalid", 64'(bus.bvalid), 64'd0);
        chk("rst_rvalid", 64'(bus.rvalid), 64'd0);
        chk("rst_bid", 64'(bus.bid), 64'd0);
        chk("rst_rid", 64'(bus.rid), 64'd0);
        chk("rst_bresp", 64'(bus.bresp), 64'd0);
        chk("rst_rresp", 64'(bus.rresp), 64'd0);
        chk("rst_rdata", bus.rdata, 64'd0);
        chk("rst_rlast", 64'(bus.rlast), 64'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("post_rst_awready", 64'(bus.awready), 64'd1);
        chk("post_rst_arready", 64'(bus.arready), 64'd1);

        //                rd   addr          len id size burst strb   seed                     wl  resp
        tbl.push_back(mk(0, 32'h0000_0100, 3,  5, 3, 2'b01, 8'hFF, 64'h1111_1111_1111_1111, 3,  2'b00));
        tbl.push_back(mk(1, 32'h0000_0100, 3,  9, 3, 2'b01, 8'h00, 64'h0,                   0,  2'b00));
        tbl.push_back(mk(0, 32'h0000_0100, 0,  2, 3, 2'b01, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 0,  2'b00));
        tbl.push_back(mk(0, 32'h0000_0100, 0,  3, 3, 2'b01, 8'h0F, 64'hAAAA_BBBB_CCCC_DDDD, 0,  2'b00));
        tbl.push_back(mk(1, 32'h0000_0100, 0,  4, 3, 2'b01, 8'h00, 64'h0,                   0,  2'b00));
        tbl.push_back(mk(0, 32'h0000_8000, 3,  6, 3, 2'b01, 8'hFF, 64'h0000_1234_0000_5678, 3,  2'b10));
        tbl.push_back(mk(1, 32'h0000_8000, 3,  7, 3, 2'b01, 8'h00, 64'h0,                   0,  2'b00));
        tbl.push_back(mk(0, 32'h0000_0300, 1,  1, 3, 2'b01, 8'hFF, 64'h0102_0304_0506_0708, 1,  2'b00));
        tbl.push_back(mk(0, 32'h0000_0300, 1,  2, 2, 2'b01, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 1,  2'b10));
        tbl.push_back(mk(1, 32'h0000_0300, 1,  3, 3, 2'b01, 8'h00, 64'h0,                   0,  2'b00));
        tbl.push_back(mk(0, 32'h0000_0300, 1,  4, 3, 2'b00, 8'hFF, 64'h7777_0000_7777_0000, 1,  2'b10));
        tbl.push_back(mk(0, 32'h0000_7FF0, 3,  8, 3, 2'b01, 8'hFF, 64'h0F0F_0F0F_0F0F_0F0F, 3,  2'b10));
        tbl.push_back(mk(1, 32'h0000_7FF0, 3,  9, 3, 2'b01, 8'h00, 64'h0,                   0,  2'b00));
        tbl.push_back(mk(0, 32'h0000_0400, 3, 10, 3, 2'b01, 8'hFF, 64'h1357_9BDF_0246_8ACE, 1,  2'b10));
        tbl.push_back(mk(1, 32'h0000_0400, 1, 11, 3, 2'b01, 8'h00, 64'h0,                   0,  2'b00));
        tbl.push_back(mk(0, 32'h0000_0500, 1, 12, 3, 2'b01, 8'hFF, 64'h2468_ACE0_1357_9BDF, 99, 2'b10));
        tbl.push_back(mk(1, 32'h0000_0500, 1, 13, 3, 2'b01, 8'h00, 64'h0,                   0,  2'b00));
        tbl.push_back(mk(1, 32'h0000_0100, 3, 14, 2, 2'b01, 8'h00, 64'h0,                   0,  2'b00));

        for (int v = 0; v < tbl.size(); v++) begin
            if (tbl[v].rd)
                read_burst(tbl[v].addr, tbl[v].len, tbl[v].id, tbl[v].size, tbl[v].burst, 16'hFFFF, 0);
            else
                write_burst(tbl[v].addr, tbl[v].len, tbl[v].id, tbl[v].size, tbl[v].burst,
                            tbl[v].strb, tbl[v].seed, tbl[v].wl, tbl[v].exp_resp, 0);
        end

        // strobe merge on word 0x20, against a fixed expectation
        push_read(32'h0000_0100, 0, 4'd1, 3'd3, 2'b01);
        sb[0].data = 64'hFFFF_FFFF_CCCC_DDDD;
        sb[0].chk_data = 1'b1;
        sb.delete();
        read_burst(32'h0000_0100, 0, 4'd1, 3'd3, 2'b01, 16'hFFFF, 0);
        chk("strobe_merge_model", mem_m[32'h20], 64'hFFFF_FFFF_CCCC_DDDD);

        // refill 0x100..0x118 and read it back with rready 1,0,0,1,0,1,1
        write_burst(32'h0000_0100, 3, 4'd5, 3'd3, 2'b01, 8'hFF, 64'h1111_1111_1111_1111, 3, 2'b00, 0);
        read_burst(32'h0000_0100, 3, 4'd9, 3'd3, 2'b01, 16'h0069, 7);

        // B held for 5 cycles while an independent read runs
        fork
            write_burst(32'h0000_0700, 3, 4'd6, 3'd3, 2'b01, 8'hFF, 64'h0101_0202_0303_0404, 3, 2'b00, 5);
            read_burst(32'h0000_0100, 3, 4'd2, 3'd3, 2'b01, 16'hFFFF, 0);
        join
        read_burst(32'h0000_0700, 3, 4'd3, 3'd3, 2'b01, 16'hFFFF, 0);

        // reset during beat 2 of a read and beat 2 of a write
        begin
            int t;
            push_read(32'h0000_0100, 3, 4'd7, 3'd3, 2'b01);
            bus.arvalid = 1'b1; bus.arid = 4'd7; bus.araddr = 32'h0000_0100;
            bus.arlen = 8'd3; bus.arsize = 3'd3; bus.arburst = 2'b01;
            t = 0;
            while (!bus.arready && t < 50) begin @(posedge clock); #1; t++; end
            @(posedge clock); #1;
            bus.arvalid = 1'b0;
            t = 0;
            while (!bus.rvalid && t < 50) begin @(posedge clock); #1; t++; end
            if (!bus.rvalid) timeout_fail("rst_r_wait");
            bus.rready = 1'b1;
            @(posedge clock); #1;
            bus.rready = 1'b0;

            bus.awvalid = 1'b1; bus.awid = 4'd3; bus.awaddr = 32'h0000_0600;
            bus.awlen = 8'd3; bus.awsize = 3'd3; bus.awburst = 2'b01;
            t = 0;
            while (!bus.awready && t < 50) begin @(posedge clock); #1; t++; end
            @(posedge clock); #1;
            bus.awvalid = 1'b0;
            bus.wvalid = 1'b1; bus.wdata = 64'h5A5A_5A5A_5A5A_5A5A; bus.wstrb = 8'hFF; bus.wlast = 1'b0;
            t = 0;
            while (!bus.wready && t < 50) begin @(posedge clock); #1; t++; end
            if (!bus.wready) timeout_fail("rst_w_wait");
            @(posedge clock); #1;
            mem_m[32'h0600 >> 3] = 64'h5A5A_5A5A_5A5A_5A5A;
            bus.wdata = 64'hA5A5_A5A5_A5A5_A5A5;
            chk("pre_rst_rvalid", 64'(bus.rvalid), 64'd1);
            chk("pre_rst_wready", 64'(bus.wready), 64'd1);
            reset = 1'b1;
            #1;
            chk("in_rst_rvalid", 64'(bus.rvalid), 64'd0);
            chk("in_rst_wready", 64'(bus.wready), 64'd0);
            chk("in_rst_bvalid", 64'(bus.bvalid), 64'd0);
            @(posedge clock); #1;
            chk("in_rst_rvalid2", 64'(bus.rvalid), 64'd0);
            chk("in_rst_wready2", 64'(bus.wready), 64'd0);
            chk("in_rst_awready", 64'(bus.awready), 64'd0);
            sb.delete();
            bus.wvalid = 1'b0;
            reset = 1'b0;
            @(posedge clock); #1;
            chk("rel_awready", 64'(bus.awready), 64'd1);
            chk("rel_arready", 64'(bus.arready), 64'd1);
            chk("rel_bvalid", 64'(bus.bvalid), 64'd0);
        end
        read_burst(32'h0000_0600, 0, 4'd4, 3'd3, 2'b01, 16'hFFFF, 0);

        repeat (3) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
